sync_filter: RTL and testbench
==============================

// Module: sync_filter
// PURPOSE
//  Multi-channel input conditioner: the parametrised successor of the plain 2-FF line synchronizer.
//  Each of WIDTH asynchronous lines passes through a SYNC_STAGES-deep flop chain, then a
//  per-channel stability filter (glitch reject). Outputs the clean level plus one-cycle rise/fall
//  pulses. Sits between external pins and protocol engines (SPI/UART/I2C sniff and MITM paths).
// PARAMETERS
//  WIDTH        4     number of independent channels
//  SYNC_STAGES  2     synchronizer flops per channel; must be >= 2
//  FILTER_LEN   3     consecutive cycles a new synced level must hold before it is accepted; >= 1
//  RESET_VAL    0     WIDTH-bit value loaded into sync chain and out_line on reset
// PORTS
//  sys_clk    in   1      system clock (12 MHz nominal)
//  sys_rst    in   1      synchronous reset, active-high
//  in_line    in   WIDTH  asynchronous input lines
//  out_line   out  WIDTH  synchronized, filtered level
//  rise_edge  out  WIDTH  one-cycle pulse per channel when out_line bit goes 0->1
//  fall_edge  out  WIDTH  one-cycle pulse per channel when out_line bit goes 1->0
// BEHAVIOUR
//  - One clock domain, all state updates on posedge sys_clk; no combinational in->out path.
//  - Reset (sys_rst=1 at an edge): every sync flop <= RESET_VAL, out_line <= RESET_VAL,
//    all counters <= 0, rise_edge/fall_edge <= 0. Reset overrides all other activity, incl. mid-filter.
//  - Sync chain per channel: s[0] <= in_line[i]; s[k] <= s[k-1]; synced[i] = s[SYNC_STAGES-1].
//  - Filter per channel (counter width max(1,$clog2(FILTER_LEN)), saturates never; cleared on accept):
//      synced == out_line             -> cnt <= 0
//      synced != out_line, cnt <  FILTER_LEN-1 -> cnt <= cnt+1
//      synced != out_line, cnt == FILTER_LEN-1 -> out_line <= synced, cnt <= 0, edge pulse
//  - A synced excursion shorter than FILTER_LEN cycles is discarded (cnt returns to 0, no pulse).
//  - FILTER_LEN=1: no filtering; out_line = synced delayed one cycle.
//  - Latency: input stable before edge 1 -> out_line takes new value after edge SYNC_STAGES+FILTER_LEN.
//  - rise_edge[i]/fall_edge[i] registered, high exactly the cycle out_line[i] first shows the new
//    value; never both set on the same channel; different channels may pulse in the same cycle.
//  - Channels fully independent; no cross-channel coupling or shared counter.
//  - Illegal parameters (SYNC_STAGES<2, FILTER_LEN<1, WIDTH<1) -> elaboration error.
//  - Sub-cycle pulses on in_line may be missed or captured by s[0]; either outcome is legal,
//    the filter then applies to whatever is captured.
// TESTING (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3, RESET_VAL=0, 12 MHz)
//  1 Reset: sys_rst=1 for 3 cycles with in_line=4'hF -> out_line=4'h0, rise/fall=0 throughout.
//  2 Step: in_line 0->4'hC held -> out_line=4'hC after exactly 5 edges; rise_edge=4'hC for 1 cycle.
//  3 Glitch: out=4'h0, in_line[0]=1 for 2 cycles -> no change/no pulse; for 3 cycles -> out_line=4'h1
//    and rise_edge=4'h1 once.
//  4 Mixed: out=4'hC, in_line->4'h3 held -> out_line=4'h3, rise_edge=4'h3 and fall_edge=4'hC same cycle.
//  5 Reset mid-filter: step 0->4'h5, assert sys_rst 3 edges later for 1 cycle -> out stays 4'h0;
//    after release out_line=4'h5 exactly 5 edges later.
//  6 Chatter: in_line toggled every quarter period (3,9,B,4,1,0,A,F) then held 4'hF -> no pulse during
//    toggling except filter-qualified; final out_line=4'hF, 5 edges after hold begins.

Source files
------------

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel synchronizer chain followed by a
// stability filter that accepts a new level only after it has held FILTER_LEN cycles.
module sync_filter #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 3,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_line,
  output logic [WIDTH-1:0] out_line,
  output logic [WIDTH-1:0] rise_edge,
  output logic [WIDTH-1:0] fall_edge
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // Reject unusable configurations at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filter: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_filter: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("sync_filter: FILTER_LEN must be >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift: stage 0 captures the pin, later stages follow.
  always_comb begin
    sync_d[0] = in_line;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel filter: count disagreement cycles, accept on the last one.
  always_comb begin
    out_d  = out_q;
    rise_d = {WIDTH{1'b0}};
    fall_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (synced_s[i] == out_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = {CNT_W{1'b0}};
        out_d[i]  = synced_s[i];
        rise_d[i] = synced_s[i];
        fall_d[i] = ~synced_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State registers; reset also aborts any filter run in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      out_q  <= RESET_VAL;
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_line  = out_q;
  assign rise_edge = rise_q;
  assign fall_edge = fall_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3, RESET_VAL=0):
// a per-cycle vector table plus a hand-timed sub-cycle chatter sequence.
module tb_sync_filter;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] in_line;
  logic [3:0] out_line;
  logic [3:0] rise_edge;
  logic [3:0] fall_edge;

  int n_checks;
  int n_fails;

  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs[$];

  sync_filter #(
    .WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3), .RESET_VAL(4'h0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_line  (in_line),
    .out_line (out_line),
    .rise_edge(rise_edge),
    .fall_edge(fall_edge)
  );

  // 84 ns period, close to 12 MHz.
  initial sys_clk = 1'b0;
  always #42 sys_clk = ~sys_clk;

  task automatic add(input logic rst, input logic [3:0] in, input logic [3:0] out,
                     input logic [3:0] rise, input logic [3:0] fall, input int n);
    vec_t v;
    v.rst = rst; v.in = in; v.out = out; v.rise = rise; v.fall = fall;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] o, input logic [3:0] r,
                           input logic [3:0] f);
    check({tag, ".out"},  out_line,  o);
    check({tag, ".rise"}, rise_edge, r);
    check({tag, ".fall"}, fall_edge, f);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    sys_rst  = 1'b1;
    in_line  = 4'hF;

    // Reset held 3 cycles with all inputs high, then idle.
    add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 3);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    // Step 0 -> C: new level appears on the 5th edge with a single rise pulse.
    add(1'b0, 4'hC, 4'h0, 4'h0, 4'h0, 4);
    add(1'b0, 4'hC, 4'hC, 4'hC, 4'h0, 1);
    add(1'b0, 4'hC, 4'hC, 4'h0, 4'h0, 2);
    // Mixed C -> 3: rise and fall on different channels in the same cycle.
    add(1'b0, 4'h3, 4'hC, 4'h0, 4'h0, 4);
    add(1'b0, 4'h3, 4'h3, 4'h3, 4'hC, 1);
    add(1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 1);
    add(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h3, 1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    // Two-cycle glitch on channel 0 is rejected.
    add(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 2);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
    // Three-cycle pulse is accepted, then its trailing edge is too.
    add(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 3);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    add(1'b0, 4'h0, 4'h1, 4'h1, 4'h0, 1);
    add(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 2);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    // Reset on the 4th edge of a 0 -> 5 step restarts the whole latency.
    add(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 3);
    add(1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1);
    add(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4);
    add(1'b0, 4'h5, 4'h5, 4'h5, 4'h0, 1);
    add(1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
    // Full inversion 5 -> A.
    add(1'b0, 4'hA, 4'h5, 4'h0, 4'h0, 4);
    add(1'b0, 4'hA, 4'hA, 4'hA, 4'h5, 1);
    add(1'b0, 4'hA, 4'hA, 4'h0, 4'h0, 2);

    foreach (vecs[v]) begin
      sys_rst = vecs[v].rst;
      in_line = vecs[v].in;
      tick();
      check_all($sformatf("vec%0d", v), vecs[v].out, vecs[v].rise, vecs[v].fall);
    end

    // Chatter from out=A: in_line changes every quarter period, so edge E1
    // samples 4 and edge E2 samples F; F is then held.
    in_line = 4'h3; #21;
    in_line = 4'h9; #21;
    in_line = 4'hB; #21;
    in_line = 4'h4; #21;
    check_all("chat_e1", 4'hA, 4'h0, 4'h0);
    in_line = 4'h1; #21;
    in_line = 4'h0; #21;
    in_line = 4'hA; #21;
    in_line = 4'hF; #21;
    check_all("chat_e2", 4'hA, 4'h0, 4'h0);
    tick(); check_all("chat_e3", 4'hA, 4'h0, 4'h0);
    tick(); check_all("chat_e4", 4'hA, 4'h0, 4'h0);
    // Channel 2 saw 1 from E1 on; channel 0 only from E2 on.
    tick(); check_all("chat_e5", 4'hE, 4'h4, 4'h0);
    tick(); check_all("chat_e6", 4'hF, 4'h1, 4'h0);
    tick(); check_all("chat_e7", 4'hF, 4'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
